// File: rtl/button_port.sv
// Two-button input port: synchronize, debounce, count presses on button 0,
// and expose STATUS/COUNT registers with an optional press interrupt.
module button_port #(
  parameter logic [31:0] BASE_ADDR       = 32'h8000_0010,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write,
  input  logic        read,
  input  logic [31:0] address,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic [1:0]  button,
  output logic        irq
);

  localparam logic [15:0] LAST     = DEBOUNCE_CYCLES - 16'd1;
  localparam logic [31:0] CNT_ADDR = BASE_ADDR + 32'd4;

  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       level;
  logic [1:0]       press;
  logic [1:0]       accept;
  logic [1:0]       rise;
  logic [1:0][15:0] cnt;
  logic [7:0]       press_count;
  logic             ie;
  logic             sel_stat;
  logic             sel_cnt;
  logic             wr_stat;
  logic             wr_cnt;
  logic             inc;
  logic [31:0]      rd_data;
  logic             unused_din;

  assign unused_din = ^{din[31:5], din[1:0]};

  assign sel_stat = (address == BASE_ADDR);
  assign sel_cnt  = (address == CNT_ADDR);
  assign wr_stat  = write & sel_stat;
  assign wr_cnt   = write & sel_cnt;

  // A change is accepted on the cycle the mismatch has lasted DEBOUNCE_CYCLES
  always_comb begin
    accept = '0;
    rise   = '0;
    for (int i = 0; i < 2; i++) begin
      accept[i] = (sync2[i] != level[i]) && (cnt[i] == LAST);
      rise[i]   = accept[i] & sync2[i];
    end
  end

  assign inc = rise[0];

  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      sel_stat: rd_data = {27'd0, ie, press, level};
      sel_cnt:  rd_data = {24'd0, press_count};
      default:  rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1       <= '0;
      sync2       <= '0;
      level       <= '0;
      cnt         <= '0;
      press       <= '0;
      press_count <= '0;
      ie          <= 1'b0;
      irq         <= 1'b0;
      dout        <= '0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if ((sync2[i] == level[i]) || accept[i])
          cnt[i] <= '0;
        else
          cnt[i] <= cnt[i] + 16'd1;
      end
      level <= level ^ accept;
      // A new press outranks a same-cycle clear
      press <= (press & ~({2{wr_stat}} & din[3:2])) | rise;
      if (wr_stat)
        ie <= din[4];
      if (wr_cnt)
        press_count <= {7'd0, inc};
      else if (inc)
        press_count <= press_count + 8'd1;
      irq  <= ie & (|press);
      dout <= read ? rd_data : 32'd0;
    end
  end

endmodule

// File: tb/tb_button_port.sv
// Self-checking bench for button_port with DEBOUNCE_CYCLES = 4.
// Bus read data is checked through a scoreboard queue.
module tb_button_port;

  localparam logic [31:0] ST = 32'h8000_0010;
  localparam logic [31:0] CT = 32'h8000_0014;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic [1:0]  btn = '0;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] d;
    string       name;
  } sb_t;
  sb_t q[$];

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t tbl[12];

  button_port #(
    .BASE_ADDR(ST),
    .DEBOUNCE_CYCLES(16'd4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .write(write),
    .read(read),
    .address(address),
    .din(din),
    .dout(dout),
    .button(btn),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("idle_dout", dout, 32'd0);
    end
  endtask

  task automatic cycle(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp,
                       input string name);
    sb_t s;
    read    = rd;
    write   = wr;
    address = a;
    din     = d;
    q.push_back('{d: exp, name: name});
    tick();
    read    = 1'b0;
    write   = 1'b0;
    address = '0;
    din     = '0;
    if (q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      s = q.pop_front();
      chk(s.name, dout, s.d);
    end
  endtask

  task automatic press0();
    btn[0] = 1'b1;
    idle(8);
    btn[0] = 1'b0;
    idle(8);
  endtask

  initial begin
    tbl[0]  = '{1, 0, ST, 32'h0, 32'h5, "tbl_rd_status"};
    tbl[1]  = '{1, 0, CT, 32'h0, 32'h1, "tbl_rd_count"};
    tbl[2]  = '{1, 0, ST + 32'd8, 32'h0, 32'h0, "tbl_rd_bad"};
    tbl[3]  = '{0, 1, ST + 32'd8, 32'hffff_ffff, 32'h0, "tbl_wr_bad"};
    tbl[4]  = '{1, 0, ST, 32'h0, 32'h5, "tbl_rd_after_bad"};
    tbl[5]  = '{1, 1, ST, 32'h14, 32'h5, "tbl_rdwr_status"};
    tbl[6]  = '{1, 0, ST, 32'h0, 32'h11, "tbl_rd_ie_set"};
    tbl[7]  = '{1, 1, CT, 32'hab, 32'h1, "tbl_rdwr_count"};
    tbl[8]  = '{1, 0, CT, 32'h0, 32'h0, "tbl_rd_count_clr"};
    tbl[9]  = '{1, 0, ST + 32'd1, 32'h0, 32'h0, "tbl_rd_unaligned"};
    tbl[10] = '{0, 1, ST, 32'h3, 32'h0, "tbl_wr_ie_off"};
    tbl[11] = '{1, 0, ST, 32'h0, 32'h1, "tbl_rd_low_bits"};

    // reset
    tick();
    tick();
    chk("rst_dout", dout, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rst = 1'b1;
    cycle(1, 0, ST, 0, 32'h0, "rst_status");
    cycle(1, 0, CT, 0, 32'h0, "rst_count");

    // clean step: accepted exactly 6 edges after the step
    btn = 2'b01;
    idle(5);
    cycle(1, 0, ST, 0, 32'h0, "step_edge6_pre");
    cycle(1, 0, ST, 0, 32'h5, "step_edge7");
    cycle(1, 0, CT, 0, 32'h1, "step_count");

    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].din,
            tbl[i].exp, tbl[i].name);
      chk({tbl[i].name, "_irq"}, {31'd0, irq}, 32'd0);
    end

    // glitch on button 1 shorter than the debounce window
    btn = 2'b11;
    idle(3);
    btn = 2'b01;
    idle(10);
    cycle(1, 0, ST, 0, 32'h1, "glitch_status");

    // release sets no flag; then set vs clear in the same cycle
    btn = 2'b00;
    idle(8);
    cycle(1, 0, ST, 0, 32'h0, "release_no_flag");
    press0();
    cycle(1, 0, ST, 0, 32'h4, "press0_flag");
    btn[0] = 1'b1;
    idle(5);
    cycle(0, 1, ST, 32'h4, 32'h0, "w1c_vs_set_wr");
    cycle(1, 0, ST, 0, 32'h5, "w1c_vs_set_status");
    cycle(1, 0, CT, 0, 32'h2, "w1c_vs_set_count");
    cycle(0, 1, ST, 32'h4, 32'h0, "w1c_wr");
    cycle(1, 0, ST, 0, 32'h1, "w1c_status");

    // increment and COUNT write in the same cycle
    btn[0] = 1'b0;
    idle(8);
    btn[0] = 1'b1;
    idle(5);
    cycle(0, 1, CT, 32'hffff_ffff, 32'h0, "inc_vs_clr_wr");
    cycle(1, 0, CT, 0, 32'h1, "inc_vs_clr_count");
    btn[0] = 1'b0;
    idle(8);

    // press_count wrap
    cycle(0, 1, CT, 0, 32'h0, "wrap_clr");
    for (int i = 0; i < 255; i++) press0();
    cycle(1, 0, CT, 0, 32'hff, "wrap_255");
    press0();
    cycle(1, 0, CT, 0, 32'h0, "wrap_256");
    press0();
    cycle(1, 0, CT, 0, 32'h1, "wrap_257");
    cycle(0, 1, CT, 0, 32'h0, "wrap_wr");
    cycle(1, 0, CT, 0, 32'h0, "wrap_after_wr");

    // interrupt on button 1
    cycle(0, 1, ST, 32'h14, 32'h0, "irq_ie_on");
    idle(2);
    chk("irq_idle", {31'd0, irq}, 32'd0);
    btn = 2'b10;
    idle(6);
    chk("irq_at_press", {31'd0, irq}, 32'd0);
    idle(1);
    chk("irq_after_press", {31'd0, irq}, 32'd1);
    cycle(1, 0, ST, 0, 32'h1a, "irq_status");
    cycle(0, 1, ST, 32'h18, 32'h0, "irq_clr_wr");
    chk("irq_clr_edge", {31'd0, irq}, 32'd1);
    idle(1);
    chk("irq_clr_next", {31'd0, irq}, 32'd0);

    // reset mid-debounce with bus traffic in the reset cycle
    btn = 2'b00;
    idle(8);
    press0();
    chk("irq_before_rst", {31'd0, irq}, 32'd1);
    btn = 2'b01;
    idle(3);
    rst = 1'b0;
    cycle(1, 1, ST, 32'h10, 32'h0, "rst_mid_dout");
    rst = 1'b1;
    chk("rst_mid_irq", {31'd0, irq}, 32'd0);
    idle(5);
    cycle(1, 0, ST, 0, 32'h0, "rst_reaccept_pre");
    cycle(1, 0, ST, 0, 32'h5, "rst_reaccept");
    cycle(1, 0, CT, 0, 32'h1, "rst_reaccept_count");
    chk("rst_irq_ie_off", {31'd0, irq}, 32'd0);

    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_leftover: got %0d entries expected 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
